// File: rtl/dsp_mac_driver_if.sv
// dsp_mac_driver_if: operand stream, result stream and DSP48A1 slice signal bundle
interface dsp_mac_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        res_cout;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce;
  logic        dsp_rst;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  modport master (
    input  in_valid, in_a, in_b, res_ready, dsp_p, dsp_carryout,
    output in_ready, res_valid, res_data, res_cout, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
  );
  modport slave (
    output in_valid, in_a, in_b, res_ready, dsp_p, dsp_carryout,
    input  in_ready, res_valid, res_data, res_cout, dsp_a, dsp_b, dsp_opmode, dsp_ce, dsp_rst
  );
endinterface

// File: rtl/dsp_mac_driver.sv
// dsp_mac_driver: feeds N_TAPS operand pairs into a DSP48A1 slice, drains LAT cycles, returns P/CARRYOUT
module dsp_mac_driver #(
  parameter int N_TAPS = 4,
  parameter int LAT = 3
) (
  input  logic CLK,
  input  logic RSTN,
  dsp_mac_driver_if.master bus
);
  localparam int CW = $clog2(N_TAPS + 1);
  localparam int DW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(N_TAPS);
  localparam logic [DW-1:0] DLAST = DW'(LAT);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [17:0] a_q, a_d, b_q, b_d;
  logic [7:0] op_q, op_d;
  logic ce_q, ce_d;
  logic rst_q, dsp_rst_q;
  logic rv_q, rv_d;
  logic [47:0] rd_q, rd_d;
  logic rc_q, rc_d;
  logic in_ready, acc;
  assign in_ready = !dsp_rst_q && (state_q == IDLE || state_q == ACCUM);
  assign acc = bus.in_valid && in_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    drn_d = drn_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    ce_d = 1'b0;
    rv_d = rv_q;
    rd_d = rd_q;
    rc_d = rc_q;
    case (state_q)
      IDLE: if (acc) begin
        a_d = bus.in_a;
        b_d = bus.in_b;
        op_d = 8'h01;
        ce_d = 1'b1;
        cnt_d = CW'(1);
        state_d = ACCUM;
      end
      ACCUM: if (acc) begin
        a_d = bus.in_a;
        b_d = bus.in_b;
        op_d = 8'h09;
        ce_d = 1'b1;
        cnt_d = cnt_q + CW'(1);
        drn_d = '0;
        state_d = (cnt_d == LAST) ? DRAIN : ACCUM;
      end
      DRAIN: if (drn_q == DLAST) begin
        rd_d = bus.dsp_p;
        rc_d = bus.dsp_carryout;
        rv_d = 1'b1;
        state_d = HOLD;
      end else begin
        a_d = '0;
        b_d = '0;
        op_d = 8'h09;
        ce_d = 1'b1;
        drn_d = drn_q + DW'(1);
      end
      HOLD: if (bus.res_ready) begin
        rv_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    rst_q <= !RSTN;
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      drn_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      ce_q <= 1'b0;
      dsp_rst_q <= 1'b1;
      rv_q <= 1'b0;
      rd_q <= '0;
      rc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      drn_q <= drn_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      ce_q <= ce_d;
      dsp_rst_q <= rst_q;
      rv_q <= rv_d;
      rd_q <= rd_d;
      rc_q <= rc_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.res_valid = rv_q;
  assign bus.res_data = rd_q;
  assign bus.res_cout = rc_q;
  assign bus.dsp_a = a_q;
  assign bus.dsp_b = b_q;
  assign bus.dsp_opmode = op_q;
  assign bus.dsp_ce = ce_q;
  assign bus.dsp_rst = dsp_rst_q;
endmodule

// File: tb/tb_dsp_mac_driver.sv
// tb_dsp_mac_driver: directed scoreboard bench with a LAT=3 DSP48A1 slice model
module tb_dsp_mac_driver;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  dsp_mac_driver_if bus();
  dsp_mac_driver #(.N_TAPS(4), .LAT(3)) dut (.CLK(clk), .RSTN(rstn), .bus(bus));
  logic [7:0] op1, op2;
  logic [47:0] m1, m2, p_q;
  logic co_q, force_co;
  always @(posedge clk) begin
    if (bus.dsp_rst) begin
      op1 <= '0;
      op2 <= '0;
      m1 <= '0;
      m2 <= '0;
      p_q <= '0;
      co_q <= 1'b0;
    end else if (bus.dsp_ce) begin
      op1 <= bus.dsp_opmode;
      m1 <= 48'(bus.dsp_a) * 48'(bus.dsp_b);
      op2 <= op1;
      m2 <= m1;
      {co_q, p_q} <= (op2[3] ? {1'b0, p_q} : 49'd0) + (op2[0] ? {1'b0, m2} : 49'd0);
    end
  end
  assign bus.dsp_p = p_q;
  assign bus.dsp_carryout = co_q | force_co;
  typedef struct {logic [47:0] d; logic c;} exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rstn && bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
      end else begin
        e = q.pop_front();
        chk("res_data", 64'(bus.res_data), 64'(e.d));
        chk("res_cout", 64'(bus.res_cout), 64'(e.c));
      end
    end
  end
  int cyc = 0, t0 = 0, lat = 0, zeros = 0, nce = 0, seq_done = 0;
  logic [7:0] ops [16];
  bit seq_on = 0;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.dsp_rst) seq_on = 0;
    else begin
      if (!seq_on && bus.dsp_ce) begin
        seq_on = 1;
        t0 = cyc;
        zeros = 0;
        nce = 0;
      end
      if (seq_on) begin
        if (bus.res_valid) begin
          seq_on = 0;
          lat = cyc - t0;
          seq_done++;
        end else if (bus.dsp_ce) begin
          if (nce < 16) ops[nce] = bus.dsp_opmode;
          nce++;
        end else zeros++;
      end
    end
  end
  task automatic send(input logic [17:0] a, input logic [17:0] b);
    bit acc = 0;
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    while (!acc && k < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask
  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_seq(input int s, input string name);
    int k = 0;
    while (seq_done == s && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_done"}, 64'(seq_done != s), 64'd1);
  endtask
  task automatic wait_empty(input string name);
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_popped"}, 64'(q.size()), 64'd0);
  endtask
  task automatic check_seq(input string name, input int e_lat, input int e_zeros);
    chk({name, "_latency"}, 64'(lat), 64'(e_lat));
    chk({name, "_ce_low"}, 64'(zeros), 64'(e_zeros));
    chk({name, "_ce_high"}, 64'(nce), 64'd7);
    chk({name, "_op0"}, 64'(ops[0]), 64'h01);
    for (int i = 1; i < 7; i++) chk({name, "_opn"}, 64'(ops[i]), 64'h09);
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({name, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({name, "_res_data"}, 64'(bus.res_data), 64'd0);
    chk({name, "_res_cout"}, 64'(bus.res_cout), 64'd0);
    chk({name, "_dsp_a"}, 64'(bus.dsp_a), 64'd0);
    chk({name, "_dsp_b"}, 64'(bus.dsp_b), 64'd0);
    chk({name, "_dsp_opmode"}, 64'(bus.dsp_opmode), 64'd0);
    chk({name, "_dsp_ce"}, 64'(bus.dsp_ce), 64'd0);
    chk({name, "_dsp_rst"}, 64'(bus.dsp_rst), 64'd1);
  endtask
  task automatic release_check(input string name);
    rstn = 1'b1;
    @(negedge clk);
    chk({name, "_rst_hold"}, 64'(bus.dsp_rst), 64'd1);
    chk({name, "_rdy_hold"}, 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    chk({name, "_rst_low"}, 64'(bus.dsp_rst), 64'd0);
    chk({name, "_rdy_high"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int s;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b1;
    force_co = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    release_check("por");
    s = seq_done;
    q.push_back('{d: 48'd39, c: 1'b0});
    send(2, 3); send(4, 5); send(1, 6); send(7, 1);
    idle(1);
    wait_seq(s, "basic");
    check_seq("basic", 7, 0);
    wait_empty("basic");
    s = seq_done;
    q.push_back('{d: 48'd39, c: 1'b0});
    send(2, 3); send(4, 5);
    idle(2);
    send(1, 6); send(7, 1);
    idle(1);
    wait_seq(s, "bubble");
    check_seq("bubble", 9, 2);
    wait_empty("bubble");
    bus.res_ready = 1'b0;
    s = seq_done;
    q.push_back('{d: 48'd39, c: 1'b0});
    send(2, 3); send(4, 5); send(1, 6); send(7, 1);
    bus.in_valid = 1'b1;
    bus.in_a = 18'd1;
    bus.in_b = 18'd1;
    wait_seq(s, "bp");
    repeat (5) begin
      @(negedge clk);
      chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_res_data", 64'(bus.res_data), 64'd39);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    s = seq_done;
    q.push_back('{d: 48'd4, c: 1'b0});
    bus.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_res_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #1;
    send(1, 1); send(1, 1); send(1, 1);
    idle(1);
    wait_seq(s, "second");
    check_seq("second", 7, 0);
    wait_empty("second");
    force_co = 1'b1;
    s = seq_done;
    q.push_back('{d: 48'h003F_FFE0_0004, c: 1'b1});
    for (int i = 0; i < 4; i++) send(18'h3FFFF, 18'h3FFFF);
    idle(1);
    wait_seq(s, "ovf");
    wait_empty("ovf");
    force_co = 1'b0;
    send(5, 5); send(6, 6);
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("mid");
    release_check("mid");
    s = seq_done;
    q.push_back('{d: 48'd119, c: 1'b0});
    send(3, 3); send(2, 5); send(0, 7); send(10, 10);
    idle(1);
    wait_seq(s, "fresh");
    check_seq("fresh", 7, 0);
    wait_empty("fresh");
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
